// File: rtl/sha2_ctrl_pkg.sv
// Shared types and constants for the multi-block SHA-2 control path.
package sha2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int SHA256_ROUNDS   = 64;
  localparam int SHA512_ROUNDS   = 80;
  localparam int WORDS_PER_BLOCK = 16;

endpackage

// File: rtl/sha2_mod_counter.sv
// Modulo-MAX counter with synchronous clear and a terminal-count flag.
module sha2_mod_counter #(
  parameter int MAX = 16,
  localparam int W  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  assign o_term = (r_cnt == W'(MAX - 1));
  assign o_cnt  = r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_term ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/sha2_multiblock_ctrl.sv
// Control FSM sequencing word intake, compression rounds and feed-forward over multi-block messages.
module sha2_multiblock_ctrl
  import sha2_ctrl_pkg::*;
#(
  parameter int ROUNDS    = SHA256_ROUNDS,
  parameter int WORDS     = WORDS_PER_BLOCK,
  parameter int BLK_CNT_W = 16,
  localparam int RND_W    = $clog2(ROUNDS),
  localparam int WRD_W    = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 msg_word_valid_i,
  output logic                 msg_word_ready_o,
  input  logic                 last_block_i,
  input  logic                 digest_ready_i,
  output logic                 msg_ld_o,
  output logic                 iv_ld_o,
  output logic                 hash_ld_o,
  output logic                 hash_en_o,
  output logic                 final_o,
  output logic                 digest_valid_o,
  output logic                 busy_o,
  output logic [RND_W-1:0]     round_o,
  output logic [WRD_W-1:0]     word_idx_o,
  output logic [BLK_CNT_W-1:0] block_cnt_o
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_first_blk;
  logic                 r_last_blk;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic [WRD_W-1:0]     w_word_cnt;
  logic                 w_word_term;
  logic [RND_W-1:0]     w_rnd_cnt;
  logic                 w_rnd_term;

  sha2_mod_counter #(.MAX(WORDS)) u_word_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (abort_i || (r_state != LOAD)),
    .i_en   (msg_ld_o),
    .o_cnt  (w_word_cnt),
    .o_term (w_word_term)
  );

  sha2_mod_counter #(.MAX(ROUNDS)) u_rnd_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (abort_i || (r_state != ROUND)),
    .i_en   (hash_en_o),
    .o_cnt  (w_rnd_cnt),
    .o_term (w_rnd_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state     = r_state;
    msg_word_ready_o = 1'b0;
    msg_ld_o         = 1'b0;
    iv_ld_o          = 1'b0;
    hash_ld_o        = 1'b0;
    hash_en_o        = 1'b0;
    final_o          = 1'b0;
    digest_valid_o   = 1'b0;
    case (r_state)
      IDLE: if (start_i) w_next_state = LOAD;
      LOAD: begin
        msg_word_ready_o = 1'b1;
        if (msg_word_valid_i) begin
          msg_ld_o = 1'b1;
          if (w_word_cnt == '0) begin
            hash_ld_o = 1'b1;
            iv_ld_o   = r_first_blk;
          end
          if (w_word_term) w_next_state = ROUND;
        end
      end
      ROUND: begin
        hash_en_o = 1'b1;
        if (w_rnd_term) w_next_state = FINAL;
      end
      FINAL: begin
        final_o      = 1'b1;
        w_next_state = r_last_blk ? DONE : LOAD;
      end
      DONE: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    // Abort overrides everything, including the intake handshake.
    if (abort_i) begin
      w_next_state     = IDLE;
      msg_word_ready_o = 1'b0;
      msg_ld_o         = 1'b0;
      iv_ld_o          = 1'b0;
      hash_ld_o        = 1'b0;
      hash_en_o        = 1'b0;
      final_o          = 1'b0;
      digest_valid_o   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_blk <= 1'b0;
      r_last_blk  <= 1'b0;
      r_blk_cnt   <= '0;
    end else if (abort_i) begin
      r_first_blk <= 1'b0;
      r_last_blk  <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_first_blk <= 1'b1;
          r_last_blk  <= 1'b0;
          r_blk_cnt   <= '0;
        end
        LOAD: if (msg_ld_o && w_word_term) r_last_blk <= last_block_i;
        FINAL: begin
          if (r_blk_cnt != '1) r_blk_cnt <= r_blk_cnt + 1'b1;
          if (!r_last_blk)     r_first_blk <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state != IDLE);
  assign round_o     = (r_state == ROUND) ? w_rnd_cnt : '0;
  assign word_idx_o  = w_word_cnt;
  assign block_cnt_o = r_blk_cnt;

endmodule

// File: tb/tb_sha2_multiblock_ctrl.sv
// Directed bench for sha2_multiblock_ctrl: 64-round and 80-round instances, cycle-indexed strobe logging.
module tb_sha2_multiblock_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start64, start80, abort, valid, last, dready;

  logic        rdy64, mld64, ivl64, hld64, en64, fin64, dv64, busy64;
  logic [5:0]  rnd64;
  logic [3:0]  widx64;
  logic [15:0] blk64;
  logic        rdy80, mld80, ivl80, hld80, en80, fin80, dv80, busy80;
  logic [6:0]  rnd80;
  logic [3:0]  widx80;
  logic [15:0] blk80;

  always #5 clk = ~clk;

  sha2_multiblock_ctrl #(.ROUNDS(64)) dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .abort_i(abort),
    .msg_word_valid_i(valid), .msg_word_ready_o(rdy64), .last_block_i(last),
    .digest_ready_i(dready), .msg_ld_o(mld64), .iv_ld_o(ivl64), .hash_ld_o(hld64),
    .hash_en_o(en64), .final_o(fin64), .digest_valid_o(dv64), .busy_o(busy64),
    .round_o(rnd64), .word_idx_o(widx64), .block_cnt_o(blk64)
  );

  sha2_multiblock_ctrl #(.ROUNDS(80)) dut80 (
    .clk(clk), .rst(rst), .start_i(start80), .abort_i(abort),
    .msg_word_valid_i(valid), .msg_word_ready_o(rdy80), .last_block_i(last),
    .digest_ready_i(dready), .msg_ld_o(mld80), .iv_ld_o(ivl80), .hash_ld_o(hld80),
    .hash_en_o(en80), .final_o(fin80), .digest_valid_o(dv80), .busy_o(busy80),
    .round_o(rnd80), .word_idx_o(widx80), .block_cnt_o(blk80)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  logic sel80;
  // Per-strobe log, index: 0 msg_ld, 1 iv_ld, 2 hash_ld, 3 hash_en, 4 final, 5 digest_valid.
  int cnt[6];
  int first[6];
  int lastc[6];
  int exp_rnd, max_rnd, rnd_err, stall_ld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_rec();
    for (int i = 0; i < 6; i++) begin
      cnt[i] = 0; first[i] = -1; lastc[i] = -1;
    end
    exp_rnd = 0; max_rnd = 0; rnd_err = 0; stall_ld = 0;
  endtask

  task automatic sample();
    logic [5:0] mon;
    int rnd;
    if (sel80) begin
      mon = {dv80, fin80, en80, hld80, ivl80, mld80}; rnd = int'(rnd80);
    end else begin
      mon = {dv64, fin64, en64, hld64, ivl64, mld64}; rnd = int'(rnd64);
    end
    for (int i = 0; i < 6; i++) begin
      if (mon[i]) begin
        if (cnt[i] == 0) first[i] = cyc;
        lastc[i] = cyc;
        cnt[i]++;
      end
    end
    if (mon[0] && !valid) stall_ld++;
    if (mon[3]) begin
      if (rnd != exp_rnd) rnd_err++;
      if (rnd > max_rnd) max_rnd = rnd;
      exp_rnd++;
    end else begin
      exp_rnd = 0;
      if (rnd != 0) rnd_err++;
    end
  endtask

  // Sample at the falling edge, then move to 1ns after the next rising edge.
  task automatic cyc_step();
    #4;
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; start64 = 0; start80 = 0; abort = 0; valid = 1; last = 0; dready = 0;
    sel80 = 0; cyc = 0;
    #2;
    check("reset_outs64", |{rdy64, mld64, ivl64, hld64, en64, fin64, dv64, busy64, rnd64, widx64, blk64}, 0);
    check("reset_outs80", |{rdy80, mld80, ivl80, hld80, en80, fin80, dv80, busy80, rnd80, widx80, blk80}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1) single block, 64 rounds
    cyc = 0; clr_rec(); last = 1;
    for (int k = 0; k < 90; k++) begin
      start64 = (cyc == 0);
      cyc_step();
    end
    check("t1_ld_cnt", cnt[0], 16);
    check("t1_ld_first", first[0], 1);
    check("t1_ld_last", lastc[0], 16);
    check("t1_iv_cnt", cnt[1], 1);
    check("t1_iv_cyc", first[1], 1);
    check("t1_hld_cnt", cnt[2], 1);
    check("t1_hld_cyc", first[2], 1);
    check("t1_en_first", first[3], 17);
    check("t1_en_last", lastc[3], 80);
    check("t1_en_cnt", cnt[3], 64);
    check("t1_fin_cnt", cnt[4], 1);
    check("t1_fin_cyc", first[4], 81);
    check("t1_dv_first", first[5], 82);
    check("t1_rnd_seq", rnd_err, 0);
    check("t1_blk_cnt", blk64, 1);
    dready = 1; cyc_step(); dready = 0;
    check("t1_idle", busy64, 0);

    // 2) two blocks; last_block_i is high except on word 15 of block 1
    cyc = 0; clr_rec();
    for (int k = 0; k < 170; k++) begin
      start64 = (cyc == 0);
      last = (cyc != 16);
      cyc_step();
    end
    check("t2_iv_cnt", cnt[1], 1);
    check("t2_hld_cnt", cnt[2], 2);
    check("t2_hld_first", first[2], 1);
    check("t2_hld_second", lastc[2], 82);
    check("t2_fin_cnt", cnt[4], 2);
    check("t2_fin_first", first[4], 81);
    check("t2_fin_second", lastc[4], 162);
    check("t2_dv_first", first[5], 163);
    check("t2_blk_cnt", blk64, 2);
    check("t2_rnd_seq", rnd_err, 0);
    last = 1;
    dready = 1; cyc_step(); dready = 0;
    check("t2_idle", busy64, 0);

    // 3) 80 rounds
    sel80 = 1; cyc = 0; clr_rec();
    for (int k = 0; k < 100; k++) begin
      start80 = (cyc == 0);
      cyc_step();
    end
    check("t3_en_cnt", cnt[3], 80);
    check("t3_en_first", first[3], 17);
    check("t3_en_last", lastc[3], 96);
    check("t3_max_round", max_rnd, 79);
    check("t3_rnd_seq", rnd_err, 0);
    check("t3_fin_cyc", first[4], 97);
    check("t3_dv_first", first[5], 98);
    dready = 1; cyc_step(); dready = 0;
    check("t3_idle", busy80, 0);
    sel80 = 0;

    // 4+5) valid low on words 5-7, then 10 cycles of back-pressure in DONE with a stray start
    cyc = 0; clr_rec();
    for (int k = 0; k < 98; k++) begin
      start64 = (cyc == 0) || (cyc == 88);
      valid = !(cyc >= 6 && cyc <= 8);
      dready = (cyc == 95);
      if (cyc == 7) check("t4_widx_stall", widx64, 5);
      cyc_step();
    end
    valid = 1; dready = 0; start64 = 0;
    check("t4_ld_cnt", cnt[0], 16);
    check("t4_ld_last", lastc[0], 19);
    check("t4_stall_ld", stall_ld, 0);
    check("t4_en_first", first[3], 20);
    check("t4_fin_cyc", first[4], 84);
    check("t5_dv_first", first[5], 85);
    check("t5_dv_last", lastc[5], 95);
    check("t5_dv_cnt", cnt[5], 11);
    check("t5_iv_cnt", cnt[1], 1);
    check("t5_idle", busy64, 0);

    // 6a) abort at round 30; start+abort together in IDLE
    cyc = 0; clr_rec();
    for (int k = 0; k < 60; k++) begin
      start64 = (cyc == 0) || (cyc == 50);
      abort = (cyc == 47) || (cyc == 50);
      if (cyc == 48) begin
        check("t6_abort_idle", busy64, 0);
        check("t6_abort_round", rnd64, 0);
        check("t6_abort_blk", blk64, 0);
      end
      if (cyc == 51) check("t6_start_abort", busy64, 0);
      cyc_step();
    end
    start64 = 0; abort = 0;
    check("t6_en_cnt", cnt[3], 30);
    check("t6_en_last", lastc[3], 46);
    check("t6_no_final", cnt[4], 0);
    check("t6_no_dv", cnt[5], 0);

    // 6b) asynchronous reset in the middle of LOAD, then a fresh message
    cyc = 0; clr_rec();
    for (int k = 0; k < 5; k++) begin
      start64 = (cyc == 0);
      cyc_step();
    end
    start64 = 0;
    check("t6_pre_rst_busy", busy64, 1);
    #2; rst = 1; #1;
    check("t6_rst_outs", |{rdy64, mld64, ivl64, hld64, en64, fin64, dv64, busy64, rnd64, widx64, blk64}, 0);
    @(posedge clk); #1;
    rst = 0;
    cyc = 0; clr_rec();
    for (int k = 0; k < 4; k++) begin
      start64 = (cyc == 0);
      cyc_step();
    end
    start64 = 0;
    check("t6_fresh_iv_cnt", cnt[1], 1);
    check("t6_fresh_iv_cyc", first[1], 1);
    check("t6_fresh_widx", widx64, 3);
    abort = 1; cyc_step(); abort = 0;
    check("t6_final_idle", busy64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
